// File: rtl/dt_pkg.sv
// Shared definitions for the distance-transform engine and its sti pack/unpack paths.
// The pixel <-> (word, bit) mapping lives here so both directions agree.
package dt_pkg;

  localparam int unsigned RES_AW   = 14;
  localparam int unsigned STI_AW   = 10;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned IMG_SIDE = 128;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } pack_state_e;

  // sti word holding pixel address a
  function automatic logic [STI_AW-1:0] pix_word(input logic [RES_AW-1:0] addr);
    return addr[RES_AW-1:4];
  endfunction

  // Bit position inside that word; leftmost pixel is the MSB
  function automatic logic [3:0] pix_bit(input logic [RES_AW-1:0] addr);
    return 4'(WORD_W - 1) - addr[3:0];
  endfunction

  function automatic logic [RES_AW-1:0] word_bit_addr(input logic [STI_AW-1:0] word_idx,
                                                      input logic [3:0]        bit_idx);
    return {word_idx, 4'(WORD_W - 1) - bit_idx};
  endfunction

endpackage

// File: rtl/bit_packer16.sv
// Serial-to-parallel packer: shifts captured bits in MSB-first and presents each full
// word for one cycle on a registered valid, without a bubble between words.
module bit_packer16 #(
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              cap_i,
  input  logic              bit_i,
  output logic              last_o,
  output logic              word_vld_o,
  output logic [WORD_W-1:0] word_o
);

  localparam int unsigned CntW = $clog2(WORD_W);

  logic [CntW-1:0]   fill_q, fill_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              vld_q, vld_d;

  // High on the capture that completes a word
  assign last_o     = cap_i && (fill_q == CntW'(WORD_W - 1));
  assign word_vld_o = vld_q;
  assign word_o     = word_q;

  always_comb begin
    shift_d = shift_q;
    fill_d  = fill_q;
    word_d  = word_q;
    vld_d   = 1'b0;
    if (clear_i) begin
      shift_d = '0;
      fill_d  = '0;
    end else if (cap_i) begin
      shift_d = {shift_q[WORD_W-2:0], bit_i};
      fill_d  = fill_q + CntW'(1);
      if (last_o) begin
        word_d = shift_d;
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      fill_q  <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      fill_q  <= fill_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: rtl/sti_packer.sv
// Reads the 128x128 res image, thresholds each pixel to one bit, packs 16 per word into
// sti format and counts foreground pixels. Every output is a flop.
module sti_packer #(
  parameter int unsigned RES_AW = dt_pkg::RES_AW,
  parameter int unsigned STI_AW = dt_pkg::STI_AW,
  parameter int unsigned PIX_W  = dt_pkg::PIX_W,
  parameter int unsigned WORD_W = dt_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  input  logic [PIX_W-1:0]  res_di,
  output logic              sti_wr,
  output logic [STI_AW-1:0] sti_addr,
  output logic [WORD_W-1:0] sti_do,
  output logic [RES_AW:0]   fg_count
);

  import dt_pkg::*;

  pack_state_e       state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              res_rd_q, res_rd_d;
  logic [RES_AW-1:0] res_addr_q, res_addr_d;
  logic              rd_dly_q;
  logic [RES_AW-1:0] pix_addr_q, pix_addr_d;
  logic [STI_AW-1:0] sti_addr_q, sti_addr_d;
  logic [RES_AW:0]   acc_q, acc_d;
  logic [RES_AW:0]   fg_count_q, fg_count_d;

  logic              clear;
  logic              cap_bit;
  logic              last_cap;
  logic              pk_vld;
  logic [WORD_W-1:0] pk_word;

  assign cap_bit = (res_di != '0);

  bit_packer16 #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (clear),
    .cap_i      (rd_dly_q),
    .bit_i      (cap_bit),
    .last_o     (last_cap),
    .word_vld_o (pk_vld),
    .word_o     (pk_word)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    res_rd_d   = res_rd_q;
    res_addr_d = res_addr_q;
    fg_count_d = fg_count_q;
    clear      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          busy_d     = 1'b1;
          res_rd_d   = 1'b1;
          res_addr_d = '0;
          clear      = 1'b1;
        end
      end
      StRun: begin
        if (res_addr_q == {RES_AW{1'b1}}) begin
          state_d  = StFlush;
          res_rd_d = 1'b0;
        end else begin
          res_addr_d = res_addr_q + RES_AW'(1);
        end
      end
      StFlush: begin
        // The only write seen in FLUSH is the final word
        if (pk_vld) begin
          state_d    = StDone;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          fg_count_d = acc_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    pix_addr_d = res_rd_q ? res_addr_q : pix_addr_q;
    sti_addr_d = last_cap ? pix_word(pix_addr_q) : sti_addr_q;

    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (rd_dly_q && cap_bit) begin
      acc_d = acc_q + (RES_AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_rd_q   <= 1'b0;
      res_addr_q <= '0;
      rd_dly_q   <= 1'b0;
      pix_addr_q <= '0;
      sti_addr_q <= '0;
      acc_q      <= '0;
      fg_count_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_rd_q   <= res_rd_d;
      res_addr_q <= res_addr_d;
      rd_dly_q   <= res_rd_q;
      pix_addr_q <= pix_addr_d;
      sti_addr_q <= sti_addr_d;
      acc_q      <= acc_d;
      fg_count_q <= fg_count_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res_rd   = res_rd_q;
  assign res_addr = res_addr_q;
  assign sti_wr   = pk_vld;
  assign sti_addr = sti_addr_q;
  assign sti_do   = pk_word;
  assign fg_count = fg_count_q;

endmodule
